alu_seq: RTL

Sequential MIPS ALU that executes the 4-bit ALU control code produced by the ALU control decoder directly upstream. Logic, add/sub and slt ops complete in one cycle. sll/srl use a bit-serial shifter that takes one cycle per shift position, so the block has a start/busy/done handshake to the multi-cycle datapath controller. Registered result and flags feed the writeback and branch-compare logic downstream.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle between the multi-cycle datapath controller and the
// sequential ALU. The controller drives the request side (master), the ALU
// returns registered result, flags and the busy/done handshake (slave).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       ALUCtrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUCtrl, A, B, shamt,
        input  result, zero, overflow, illegal, busy, done
    );

    modport slave (
        input  start, ALUCtrl, A, B, shamt,
        output result, zero, overflow, illegal, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential MIPS ALU. Logic, add/sub and slt complete on the accepting edge;
// sll/srl run through a one-bit-per-cycle shifter with a busy/done handshake.
// Result and flags are registered and only change on a completion or reset.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Signed overflow of a+b: operands agree in sign, sum does not.
    function automatic logic add_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow of a-b: operands differ in sign, difference differs from a.
    function automatic logic sub_overflow(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] d);
        return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [4:0]       cnt_r;
    logic             dir_left_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             overflow_r;
    logic             illegal_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic             add_ovf_s;
    logic             sub_ovf_s;
    logic             lt_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_ovf_s;
    logic             alu_ill_s;
    logic             is_shift_s;

    // Single-cycle datapath: evaluate the requested op from the live operands.
    always_comb begin
        sum_s      = bus.A + bus.B;
        diff_s     = bus.A - bus.B;
        add_ovf_s  = add_overflow(bus.A, bus.B, sum_s);
        sub_ovf_s  = sub_overflow(bus.A, bus.B, diff_s);
        // true signed less-than, valid even when A-B wraps
        lt_s       = diff_s[WIDTH-1] ^ sub_ovf_s;
        alu_res_s  = {WIDTH{1'b0}};
        alu_ovf_s  = 1'b0;
        alu_ill_s  = 1'b0;
        is_shift_s = 1'b0;
        case (bus.ALUCtrl)
            OP_AND: alu_res_s = bus.A & bus.B;
            OP_OR:  alu_res_s = bus.A | bus.B;
            OP_XOR: alu_res_s = bus.A ^ bus.B;
            OP_ADD: begin
                alu_res_s = sum_s;
                alu_ovf_s = add_ovf_s;
            end
            OP_SUB: begin
                alu_res_s = diff_s;
                alu_ovf_s = sub_ovf_s;
            end
            OP_SLT: alu_res_s = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLL: is_shift_s = 1'b1;
            OP_SRL: is_shift_s = 1'b1;
            default: alu_ill_s = 1'b1;
        endcase
    end

    // Control FSM plus registered result, flags and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= 5'd0;
            dir_left_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
            zero_r     <= 1'b0;
            overflow_r <= 1'b0;
            illegal_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_shift_s) begin
                            acc_r      <= bus.B;
                            cnt_r      <= bus.shamt;
                            dir_left_r <= (bus.ALUCtrl == OP_SLL);
                            // a zero-length shift finishes on the next edge, so it never reports busy
                            busy_r     <= (bus.shamt != 5'd0);
                            state_r    <= ST_SHIFT;
                        end else begin
                            result_r   <= alu_res_s;
                            zero_r     <= (alu_res_s == {WIDTH{1'b0}});
                            overflow_r <= alu_ovf_s;
                            illegal_r  <= alu_ill_s;
                            done_r     <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == 5'd0) begin
                        result_r   <= acc_r;
                        zero_r     <= (acc_r == {WIDTH{1'b0}});
                        overflow_r <= 1'b0;
                        illegal_r  <= 1'b0;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        if (dir_left_r) begin
                            acc_r <= {acc_r[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_r <= {1'b0, acc_r[WIDTH-1:1]};
                        end
                        cnt_r <= cnt_r - 5'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.result   = result_r;
    assign bus.zero     = zero_r;
    assign bus.overflow = overflow_r;
    assign bus.illegal  = illegal_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

endmodule
